// File: rtl/mult_div_unit_if.sv
// Handshake bundle between the E stage and the multiply/divide unit.
// The E stage is the master; the unit is the slave.
interface mult_div_unit_if;
  logic        req;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] HI_LO;

  modport master (
    output req,
    output start,
    output op,
    output rs_data,
    output rt_data,
    input  busy,
    input  HI_LO
  );

  modport slave (
    input  req,
    input  start,
    input  op,
    input  rs_data,
    input  rt_data,
    output busy,
    output HI_LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning the HI/LO registers.
// Results are computed at accept and held back for a fixed busy period.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;

  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic        is_mtlo;
  logic        sgn;
  logic        accept;
  logic        div_zero;

  logic        a_neg;
  logic        b_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Opcode decode for the accept path.
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    sgn     = 1'b0;
    unique case (bus.op)
      OP_MULT: begin
        is_mul = 1'b1;
        sgn    = 1'b1;
      end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV: begin
        is_div = 1'b1;
        sgn    = 1'b1;
      end
      OP_DIVU: is_div  = 1'b1;
      OP_MTHI: is_mthi = 1'b1;
      OP_MTLO: is_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign accept = bus.start & ~bus.req & (state == S_IDLE)
                & (is_mul | is_div | is_mthi | is_mtlo);
  assign div_zero = (bus.rt_data == 32'd0);

  // Product and sign-magnitude quotient/remainder of the current operands.
  always_comb begin
    a_neg = sgn & bus.rs_data[31];
    b_neg = sgn & bus.rt_data[31];
    a_ext = {{32{a_neg}}, bus.rs_data};
    b_ext = {{32{b_neg}}, bus.rt_data};
    prod  = a_ext * b_ext;
    a_mag = a_neg ? (32'd0 - bus.rs_data) : bus.rs_data;
    b_mag = b_neg ? (32'd0 - bus.rt_data) : bus.rt_data;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Accept ops, count out the busy period, then commit to HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_mul: begin
                pend_hi <= prod[63:32];
                pend_lo <= prod[31:0];
                cnt     <= MUL_LOAD;
                state   <= S_RUN;
              end
              is_div: begin
                if (!div_zero) begin
                  pend_hi <= rem;
                  pend_lo <= quo;
                  cnt     <= DIV_LOAD;
                  state   <= S_RUN;
                end
              end
              is_mthi: hi <= bus.rs_data;
              is_mtlo: lo <= bus.rs_data;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (cnt == '0) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == S_RUN);

  // Move-from read port shows committed HI/LO only.
  always_comb begin
    bus.HI_LO = 32'd0;
    if (bus.op == OP_MFHI) bus.HI_LO = hi;
    else if (bus.op == OP_MFLO) bus.HI_LO = lo;
  end

endmodule
